// File: rtl/dmem_responder.sv
// dmem_responder: word-addressed data RAM behind a fixed-latency handshake.
// A load/store request seen in IDLE is latched, the core is stalled while a
// countdown runs, the array is accessed on the last stall edge and the
// result is presented with a one-cycle done pulse in RESP.
module dmem_responder #(
    parameter int DEPTH = 256,
    parameter int WAIT  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        memread,
    input  logic        memwrite,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        stall,
    output logic        done,
    output logic        err,
    output logic [1:0]  dbg_state
);
    // Handshake: a request (memread|memwrite) is accepted in IDLE in the same
    // cycle it is raised; stall is high from that cycle until the access edge;
    // done (qualified by err) is high for exactly the following cycle, during
    // which the requester must hold off because inputs are ignored.

    localparam int         AW     = $clog2(DEPTH);
    localparam logic [3:0] WAIT_C = 4'(WAIT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [3:0]    cnt;
    logic          req;
    logic          fire;

    logic [AW-1:0] lat_idx;
    logic          lat_mis;
    logic          lat_wr;
    logic          lat_conf;
    logic [31:0]   lat_wdata;

    logic [AW-1:0] acc_idx;
    logic          acc_mis;
    logic          acc_wr;
    logic          acc_conf;
    logic [31:0]   acc_wdata;

    logic [31:0]   mem [DEPTH];

    // Address bits above the word index are deliberately ignored (wrap).
    logic          unused_addr;
    assign unused_addr = ^addr[31:AW+2];

    assign req       = memread | memwrite;
    assign dbg_state = state;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next state, stall/done and the access strobe; reset silences stall.
    always_comb begin
        state_nxt = state;
        stall     = 1'b0;
        done      = 1'b0;
        fire      = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    stall = 1'b1;
                    if (WAIT_C == 4'd0) begin
                        fire      = 1'b1;
                        state_nxt = RESP;
                    end else begin
                        state_nxt = BUSY;
                    end
                end
            end
            BUSY: begin
                stall = 1'b1;
                if (cnt == 4'd1) begin
                    fire      = 1'b1;
                    state_nxt = RESP;
                end
            end
            RESP: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (rst) begin
            stall = 1'b0;
            fire  = 1'b0;
        end
    end

    // Access operands: live inputs when firing straight from IDLE, else the latch.
    always_comb begin
        if (state == IDLE) begin
            acc_idx   = addr[AW+1:2];
            acc_mis   = |addr[1:0];
            acc_wr    = memwrite;
            acc_conf  = memread & memwrite;
            acc_wdata = wdata;
        end else begin
            acc_idx   = lat_idx;
            acc_mis   = lat_mis;
            acc_wr    = lat_wr;
            acc_conf  = lat_conf;
            acc_wdata = lat_wdata;
        end
    end

    // Request latch, latency counter, registered load data and error flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= 4'd0;
            lat_idx   <= '0;
            lat_mis   <= 1'b0;
            lat_wr    <= 1'b0;
            lat_conf  <= 1'b0;
            lat_wdata <= 32'd0;
            rdata     <= 32'd0;
            err       <= 1'b0;
        end else begin
            if (state == IDLE && req) begin
                lat_idx   <= addr[AW+1:2];
                lat_mis   <= |addr[1:0];
                lat_wr    <= memwrite;
                lat_conf  <= memread & memwrite;
                lat_wdata <= wdata;
                cnt       <= WAIT_C;
            end else if (state == BUSY) begin
                cnt <= cnt - 4'd1;
            end
            if (fire) begin
                err <= acc_mis | acc_conf;
                if (!acc_wr) rdata <= acc_mis ? 32'd0 : mem[acc_idx];
            end else if (state == RESP) begin
                err <= 1'b0;
            end
        end
    end

    // Array write: aligned stores only, on the access edge (never under reset).
    always_ff @(posedge clk) begin
        if (fire && acc_wr && !acc_mis) mem[acc_idx] <= acc_wdata;
    end

endmodule
